atm_session_ctrl: RTL

- User-facing session sequencer that drives the ATM transaction core from the command side.
- Turns debounced button pulses and a 12-bit switch word into the core's one-hot `current_state`, its latched operand registers and one-cycle `ready` strobes.
- Samples the core's `status_code` a fixed number of cycles after each strobe and branches to SUCCESS or ERROR.
- Sits between board I/O (buttons, switches, LEDs) and the ATM core; replaces the hand-driven bench stimulus.

---
 rtl/atm_pkg.sv | 50 +++++
 rtl/atm_cmd_timer.sv | 39 +++
 rtl/atm_session_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/atm_pkg.sv
// Shared ATM definitions: one-hot session states, currency and
// status codes, and the latched operand bundle.
package atm_pkg;

  typedef enum logic [15:0] {
    S_IDLE             = 16'h0001,
    S_ACC_NUM          = 16'h0002,
    S_PIN_INPUT        = 16'h0004,
    S_MENU             = 16'h0008,
    S_SHOW_BALANCES    = 16'h0010,
    S_CONVERT_CURRENCY = 16'h0020,
    S_SEL_CUR_CONV_1   = 16'h0040,
    S_SEL_CUR_CONV_2   = 16'h0080,
    S_WITHDRAW         = 16'h0100,
    S_SEL_AMT_WITHDRAW = 16'h0200,
    S_TRANSFER         = 16'h0400,
    S_SEL_CUR_TRANSFER = 16'h0800,
    S_SEL_AMT_TRANSFER = 16'h1000,
    S_ERROR            = 16'h2000,
    S_SUCCESS          = 16'h4000
  } state_t;

  localparam logic [2:0] CUR_USD = 3'd0;
  localparam logic [2:0] CUR_BTC = 3'd1;
  localparam logic [2:0] CUR_ETH = 3'd2;
  localparam logic [2:0] CUR_XRP = 3'd3;
  localparam logic [2:0] CUR_LTC = 3'd4;

  localparam logic [3:0] ST_NONE         = 4'd0;
  localparam logic [3:0] ST_OK           = 4'd1;
  localparam logic [3:0] ST_BAD_ACC      = 4'd2;
  localparam logic [3:0] ST_BAD_PIN      = 4'd3;
  localparam logic [3:0] ST_INSUFFICIENT = 4'd4;
  localparam logic [3:0] ST_BAD_DEST     = 4'd5;

  typedef struct packed {
    logic [11:0] acc;
    logic [3:0]  pin;
    logic [1:0]  menu;
    logic [2:0]  cur_src;
    logic [2:0]  cur_dst;
    logic [10:0] amount;
    logic [11:0] dest;
  } ops_t;

  function automatic logic bad_cur(input logic [2:0] c);
    return c > CUR_LTC;
  endfunction

endpackage

// File: rtl/atm_cmd_timer.sv
// Command strobe timer: one-cycle ready after start, busy until the
// response sample point RESP_WAIT cycles later.
// Ports: clk, rst_n, start (in); ready, busy, sample (out).
module atm_cmd_timer #(
  parameter int unsigned RESP_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic ready,
  output logic busy,
  output logic sample
);

  localparam int unsigned CW = $clog2(RESP_WAIT + 1) + 1;

  logic [CW-1:0] cnt;

  // cnt is 0 in the ready cycle, so the sample lands RESP_WAIT later
  assign sample = busy && (cnt == CW'(RESP_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
    end else begin
      ready <= start;
      if (start) begin
        busy <= 1'b1;
        cnt  <= '0;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
        if (sample) busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: buttons + switch word in, one-hot state,
// latched operands and ready strobes out to the ATM core.
// Ports: clk, rst_n, btn_enter, btn_back, sw_data, status_code (in);
// current_state, ready, operands, busy, session_active,
// pin_fail_count (out).
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned RESP_WAIT      = 4,
  parameter int unsigned MAX_PIN_TRIES  = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MSG_HOLD       = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_enter,
  input  logic        btn_back,
  input  logic [11:0] sw_data,
  input  logic [3:0]  status_code,
  output logic [15:0] current_state,
  output logic        ready,
  output logic [11:0] accNumber,
  output logic [3:0]  pin,
  output logic [1:0]  menuOption,
  output logic [2:0]  currency_type_in,
  output logic [2:0]  currency_type_2_in,
  output logic [10:0] amount,
  output logic [11:0] destinationAcc,
  output logic        busy,
  output logic        session_active,
  output logic [1:0]  pin_fail_count
);

  state_t      st_q, st_d, home;
  ops_t        ops_q, ops_d;
  logic        act_q, act_d;
  logic [1:0]  pfc_q, pfc_d;
  logic        start, sample, kill;
  logic        enter, back, ok;
  logic [2:0]  cur;
  logic [10:0] amt;
  logic [31:0] to_cnt, msg_cnt;
  logic        to_run, to_hit, in_msg, msg_hit;

  atm_cmd_timer #(
    .RESP_WAIT (RESP_WAIT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .ready  (ready),
    .busy   (busy),
    .sample (sample)
  );

  // back overrides enter; both are dead while a command is in flight
  assign enter = btn_enter & ~btn_back & ~busy;
  assign back  = btn_back & ~busy;
  assign ok    = (status_code == ST_OK);
  assign cur   = sw_data[2:0];
  assign amt   = sw_data[10:0];
  assign home  = act_q ? S_MENU : S_IDLE;

  assign to_run  = ~busy & ~btn_enter & ~btn_back;
  assign to_hit  = to_run && (to_cnt == TIMEOUT_CYCLES - 1);
  assign in_msg  = (st_q == S_SUCCESS) || (st_q == S_ERROR);
  assign msg_hit = in_msg && (msg_cnt == MSG_HOLD - 1);

  always_comb begin
    st_d  = st_q;
    ops_d = ops_q;
    act_d = act_q;
    pfc_d = pfc_q;
    start = 1'b0;
    kill  = 1'b0;
    if (sample) begin
      unique case (st_q)
        S_ACC_NUM:
          st_d = ok ? S_PIN_INPUT : S_ERROR;
        S_PIN_INPUT: begin
          if (ok) begin
            st_d  = S_MENU;
            act_d = 1'b1;
            pfc_d = '0;
          end else if (32'(pfc_q) + 32'd1
                       >= MAX_PIN_TRIES) begin
            st_d = S_ERROR;
            kill = 1'b1;
          end else begin
            pfc_d = pfc_q + 2'd1;
          end
        end
        S_TRANSFER:
          st_d = ok ? S_SEL_CUR_TRANSFER : S_ERROR;
        S_SEL_CUR_CONV_2,
        S_SEL_AMT_WITHDRAW,
        S_SEL_AMT_TRANSFER:
          st_d = ok ? S_SUCCESS : S_ERROR;
        default: ;
      endcase
    end else if (back) begin
      if (st_q == S_MENU) begin
        st_d = S_IDLE;
        kill = 1'b1;
      end else if (st_q != S_IDLE) begin
        st_d = home;
      end
    end else if (enter) begin
      unique case (st_q)
        S_IDLE:
          st_d = S_ACC_NUM;
        S_ACC_NUM: begin
          ops_d.acc = sw_data;
          start     = 1'b1;
        end
        S_PIN_INPUT: begin
          ops_d.pin = sw_data[3:0];
          start     = 1'b1;
        end
        S_MENU: begin
          ops_d.menu = sw_data[1:0];
          unique case (sw_data[1:0])
            2'd0: begin
              st_d  = S_SHOW_BALANCES;
              start = 1'b1;
            end
            2'd1: st_d = S_CONVERT_CURRENCY;
            2'd2: st_d = S_WITHDRAW;
            2'd3: st_d = S_TRANSFER;
          endcase
        end
        S_SHOW_BALANCES:
          st_d = S_MENU;
        S_CONVERT_CURRENCY: begin
          ops_d.cur_src = cur;
          st_d = bad_cur(cur) ? S_ERROR
                              : S_SEL_CUR_CONV_1;
        end
        S_SEL_CUR_CONV_1: begin
          ops_d.cur_dst = cur;
          st_d = (bad_cur(cur) || cur == ops_q.cur_src)
                 ? S_ERROR : S_SEL_CUR_CONV_2;
        end
        S_WITHDRAW: begin
          ops_d.cur_src = cur;
          st_d = bad_cur(cur) ? S_ERROR
                              : S_SEL_AMT_WITHDRAW;
        end
        S_TRANSFER: begin
          ops_d.dest = sw_data;
          start      = 1'b1;
        end
        S_SEL_CUR_TRANSFER: begin
          ops_d.cur_src = cur;
          st_d = bad_cur(cur) ? S_ERROR
                              : S_SEL_AMT_TRANSFER;
        end
        S_SEL_CUR_CONV_2,
        S_SEL_AMT_WITHDRAW,
        S_SEL_AMT_TRANSFER: begin
          ops_d.amount = amt;
          if (amt == '0) st_d = S_ERROR;
          else start = 1'b1;
        end
        S_ERROR,
        S_SUCCESS:
          st_d = home;
        default: ;
      endcase
    end else if (to_hit) begin
      st_d = S_IDLE;
      kill = 1'b1;
    end else if (msg_hit) begin
      st_d = home;
    end
    if (kill) begin
      act_d = 1'b0;
      pfc_d = '0;
      ops_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= S_IDLE;
      ops_q <= '0;
      act_q <= 1'b0;
      pfc_q <= '0;
    end else begin
      st_q  <= st_d;
      ops_q <= ops_d;
      act_q <= act_d;
      pfc_q <= pfc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      msg_cnt <= '0;
    end else begin
      if (!to_run || to_hit) to_cnt <= '0;
      else to_cnt <= to_cnt + 32'd1;
      if (!in_msg || msg_hit) msg_cnt <= '0;
      else msg_cnt <= msg_cnt + 32'd1;
    end
  end

  assign current_state      = st_q;
  assign accNumber          = ops_q.acc;
  assign pin                = ops_q.pin;
  assign menuOption         = ops_q.menu;
  assign currency_type_in   = ops_q.cur_src;
  assign currency_type_2_in = ops_q.cur_dst;
  assign amount             = ops_q.amount;
  assign destinationAcc     = ops_q.dest;
  assign session_active     = act_q;
  assign pin_fail_count     = pfc_q;

endmodule
